// File: rtl/paddle_controller_if.sv
// Paddle controller signal bundle: frame tick, raw buttons and recenter in,
// registered paddle position and speed out.
interface paddle_controller_if;
  logic       timing_tick;
  logic       btn_up;
  logic       btn_down;
  logic       recenter;
  logic [9:0] y_pad;
  logic [3:0] pad_speed;

  modport master (
    output timing_tick, btn_up, btn_down, recenter,
    input  y_pad, pad_speed
  );

  modport slave (
    input  timing_tick, btn_up, btn_down, recenter,
    output y_pad, pad_speed
  );
endinterface

// File: rtl/paddle_controller.sv
// Paddle controller: synchronises and debounces two push-buttons, then moves
// the paddle once per frame tick with a speed that ramps while a button is
// held. Position is clamped to the visible area; recenter returns it to the
// middle and overrides a coincident tick.
module paddle_controller #(
  parameter int SCREEN_H        = 768,
  parameter int PAD_HEIGHT      = 72,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int V_MIN           = 1,
  parameter int V_MAX           = 6,
  parameter int ACCEL_TICKS     = 8
) (
  input logic                clk,
  input logic                rst,
  paddle_controller_if.slave pif
);

  localparam int Y_MAX  = SCREEN_H - PAD_HEIGHT;
  localparam int Y_CTR  = Y_MAX / 2;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0]       Y_MAX_W = 11'(Y_MAX);
  localparam logic [9:0]        Y_CTR_L = 10'(Y_CTR);
  localparam logic [3:0]        V_MIN_L = 4'(V_MIN);
  localparam logic [3:0]        V_MAX_L = 4'(V_MAX);
  localparam logic [HOLD_W-1:0] ACCEL_L = HOLD_W'(ACCEL_TICKS);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

  logic              up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
  logic              up_db_q, up_db_d, dn_db_q, dn_db_d;
  logic [DB_W-1:0]   up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  state_t            state_q, state_d, dir;
  logic [9:0]        y_q, y_d;
  logic [3:0]        spd_q, spd_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;

  // Counter restarts whenever the synced level agrees with the accepted level;
  // the accepted level flips only after DEBOUNCE_CYCLES disagreeing cycles.
  function automatic logic [DB_W:0] debounce_next(input logic sync, input logic db,
                                                  input logic [DB_W-1:0] cnt);
    if (sync == db)     return {db, {DB_W{1'b0}}};
    if (cnt == DB_LAST) return {~db, {DB_W{1'b0}}};
    return {db, cnt + DB_W'(1)};
  endfunction

  // Speed ramps by one and saturates at V_MAX.
  function automatic logic [3:0] sat_inc(input logic [3:0] spd);
    return (spd >= V_MAX_L) ? V_MAX_L : spd + 4'd1;
  endfunction

  // Move by spd lines with 11-bit headroom so neither limit can wrap.
  function automatic logic [9:0] move_y(input logic [9:0] y, input logic [3:0] spd,
                                        input logic up);
    logic [10:0] y_w, s_w, sum;
    y_w = {1'b0, y};
    s_w = {7'd0, spd};
    sum = y_w + s_w;
    if (up) return (y_w >= s_w) ? 10'(y_w - s_w) : 10'd0;
    return (sum <= Y_MAX_W) ? 10'(sum) : 10'(Y_MAX_W);
  endfunction

  // Debounce both synchronised button levels.
  always_comb begin
    {up_db_d, up_cnt_d} = debounce_next(up_s2_q, up_db_q, up_cnt_q);
    {dn_db_d, dn_cnt_d} = debounce_next(dn_s2_q, dn_db_q, dn_cnt_q);
  end

  // Direction decode and per-tick paddle FSM; recenter wins over the tick.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    spd_d    = spd_q;
    hold_d   = hold_q;
    hold_inc = hold_q + HOLD_W'(1);
    dir      = IDLE;
    if (up_db_q && !dn_db_q)      dir = MOVE_UP;
    else if (dn_db_q && !up_db_q) dir = MOVE_DOWN;

    if (pif.recenter) begin
      y_d     = Y_CTR_L;
      state_d = IDLE;
      spd_d   = V_MIN_L;
      hold_d  = '0;
    end else if (pif.timing_tick) begin
      if (dir != state_q) begin
        state_d = dir;
        spd_d   = V_MIN_L;
        if (dir == IDLE) begin
          hold_d = '0;
        end else begin
          y_d    = move_y(y_q, V_MIN_L, dir == MOVE_UP);
          hold_d = HOLD_W'(1);
        end
      end else if (state_q != IDLE) begin
        y_d = move_y(y_q, spd_q, state_q == MOVE_UP);
        if (hold_inc == ACCEL_L) begin
          hold_d = '0;
          spd_d  = sat_inc(spd_q);
        end else begin
          hold_d = hold_inc;
        end
      end
    end
  end

  // Register synchronisers, debounce state and paddle state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_s1_q  <= 1'b0;
      up_s2_q  <= 1'b0;
      dn_s1_q  <= 1'b0;
      dn_s2_q  <= 1'b0;
      up_db_q  <= 1'b0;
      dn_db_q  <= 1'b0;
      up_cnt_q <= '0;
      dn_cnt_q <= '0;
      state_q  <= IDLE;
      y_q      <= Y_CTR_L;
      spd_q    <= V_MIN_L;
      hold_q   <= '0;
    end else begin
      up_s1_q  <= pif.btn_up;
      up_s2_q  <= up_s1_q;
      dn_s1_q  <= pif.btn_down;
      dn_s2_q  <= dn_s1_q;
      up_db_q  <= up_db_d;
      dn_db_q  <= dn_db_d;
      up_cnt_q <= up_cnt_d;
      dn_cnt_q <= dn_cnt_d;
      state_q  <= state_d;
      y_q      <= y_d;
      spd_q    <= spd_d;
      hold_q   <= hold_d;
    end
  end

  assign pif.y_pad     = y_q;
  assign pif.pad_speed = spd_q;

endmodule
